// File: rtl/stream_checker_pkg.sv
// Shared types and LFSR helper for the stream checker: state encoding,
// the Galois tap constant and the one-step LFSR advance.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_e;

    // x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Galois right-shift: the bit shifted out of bit 0 folds back via the taps
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

endpackage

// File: rtl/stream_checker_lfsr_gen.sv
// 32-bit Galois LFSR producing the expected word sequence; load has
// priority over advance so a restart always begins at seed_i.
module lfsr_gen
    import stream_checker_pkg::*;
#(
    parameter logic [31:0] Seed = 32'hCAFE_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/stream_checker.sv
// Checks a burst of Depth words against an LFSR reference sequence and
// reports sticky pass / mismatch / idle-timeout status.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int          Depth         = 4,
    parameter int          DataWidth     = 32,
    parameter logic [31:0] Seed          = 32'hCAFE_0001,
    parameter int          TimeoutCycles = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       valid_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       error_o,
    output logic                       timeout_o,
    output logic [$clog2(Depth)-1:0]   err_idx_o,
    output logic [DataWidth-1:0]       err_data_o
);

    localparam int CntW  = $clog2(Depth);
    localparam int IdleW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0]  LastIdx  = CntW'(Depth - 1);
    localparam logic [IdleW-1:0] IdleLim  = IdleW'(TimeoutCycles);

    state_e               state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [IdleW-1:0]     idle_q, idle_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 error_q, error_d;
    logic                 timeout_q, timeout_d;
    logic [CntW-1:0]      err_idx_q, err_idx_d;
    logic [DataWidth-1:0] err_data_q, err_data_d;

    logic                 lfsr_load;
    logic                 lfsr_en;
    logic [31:0]          lfsr_state;
    logic [DataWidth-1:0] expected;
    logic [IdleW-1:0]     idle_inc;

    lfsr_gen #(
        .Seed (Seed)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (lfsr_load),
        .seed_i  (Seed),
        .en_i    (lfsr_en),
        .state_o (lfsr_state)
    );

    assign expected = lfsr_state[DataWidth-1:0];
    assign idle_inc = idle_q + IdleW'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idle_d     = idle_q;
        done_d     = done_q;
        pass_d     = pass_q;
        error_d    = error_q;
        timeout_d  = timeout_q;
        err_idx_d  = err_idx_q;
        err_data_d = err_data_q;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;

        // Any start (armed or not) reseeds and clears; a word arriving with it is dropped
        if (start_i) begin
            state_d    = ARMED;
            lfsr_load  = 1'b1;
            count_d    = '0;
            idle_d     = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            error_d    = 1'b0;
            timeout_d  = 1'b0;
            err_idx_d  = '0;
            err_data_d = '0;
        end else if (state_q == ARMED) begin
            if (valid_i) begin
                if (data_i == expected) begin
                    if (count_q == LastIdx) begin
                        state_d = PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        count_d = count_q + CntW'(1);
                        idle_d  = '0;
                        lfsr_en = 1'b1;
                    end
                end else begin
                    state_d    = FAIL;
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                    err_idx_d  = count_q;
                    err_data_d = data_i;
                end
            end else if (idle_inc == IdleLim) begin
                state_d   = FAIL;
                done_d    = 1'b1;
                error_d   = 1'b1;
                timeout_d = 1'b1;
                err_idx_d = count_q;
            end else begin
                idle_d = idle_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            err_idx_q  <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
            err_idx_q  <= err_idx_d;
            err_data_q <= err_data_d;
        end
    end

    assign busy_o     = (state_q == ARMED);
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign error_o    = error_q;
    assign timeout_o  = timeout_q;
    assign err_idx_o  = err_idx_q;
    assign err_data_o = err_data_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: a behavioural model compared every
// falling edge, plus literal expectations at the end of each scenario.
module tb_stream_checker;

    localparam int          DEPTH = 4;
    localparam int          DW    = 32;
    localparam int          TO    = 64;
    localparam logic [31:0] SEED  = 32'hCAFE_0001;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data  = '0;

    logic          busy_o, done_o, pass_o, error_o, timeout_o;
    logic [1:0]    err_idx_o;
    logic [DW-1:0] err_data_o;

    int total = 0;
    int bad   = 0;

    // Reference burst, hand-derived from seed CAFE0001 with taps 80200003
    logic [31:0] words [4] = '{32'hCAFE_0001, 32'hE55F_0003, 32'hF28F_8002, 32'h7947_C001};

    stream_checker #(
        .Depth         (DEPTH),
        .DataWidth     (DW),
        .Seed          (SEED),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .valid_i    (valid),
        .data_i     (data),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .error_o    (error_o),
        .timeout_o  (timeout_o),
        .err_idx_o  (err_idx_o),
        .err_data_o (err_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        return (s >> 1) ^ ({32{s[0]}} & 32'h8020_0003);
    endfunction

    // Behavioural model: armed flag, expected word, word index, idle run length
    logic          m_busy = 0, m_done = 0, m_pass = 0, m_err = 0, m_to = 0;
    logic [1:0]    m_idx  = '0;
    logic [DW-1:0] m_data = '0;
    logic [31:0]   m_lfsr = SEED;
    int            m_k    = 0;
    int            m_idle = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_pass <= 0; m_err <= 0; m_to <= 0;
            m_idx <= '0; m_data <= '0; m_lfsr <= SEED; m_k <= 0; m_idle <= 0;
        end else if (start) begin
            m_busy <= 1; m_done <= 0; m_pass <= 0; m_err <= 0; m_to <= 0;
            m_idx <= '0; m_data <= '0; m_lfsr <= SEED; m_k <= 0; m_idle <= 0;
        end else if (m_busy) begin
            if (valid) begin
                if (data == m_lfsr[DW-1:0]) begin
                    if (m_k == DEPTH - 1) begin
                        m_busy <= 0; m_done <= 1; m_pass <= 1;
                    end else begin
                        m_k <= m_k + 1; m_lfsr <= ref_next(m_lfsr); m_idle <= 0;
                    end
                end else begin
                    m_busy <= 0; m_done <= 1; m_err <= 1;
                    m_idx <= 2'(m_k); m_data <= data;
                end
            end else if (m_idle + 1 == TO) begin
                m_busy <= 0; m_done <= 1; m_err <= 1; m_to <= 1; m_idx <= 2'(m_k);
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",     {31'd0, busy_o},    {31'd0, m_busy});
        chk("cyc_done",     {31'd0, done_o},    {31'd0, m_done});
        chk("cyc_pass",     {31'd0, pass_o},    {31'd0, m_pass});
        chk("cyc_error",    {31'd0, error_o},   {31'd0, m_err});
        chk("cyc_timeout",  {31'd0, timeout_o}, {31'd0, m_to});
        chk("cyc_err_idx",  {30'd0, err_idx_o}, {30'd0, m_idx});
        chk("cyc_err_data", err_data_o,         m_data);
    end

    task automatic step(input logic st, input logic v, input logic [31:0] d);
        start = st;
        valid = v;
        data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy_o},    32'd0);
        chk({tag, "_done"},  {31'd0, done_o},    32'd0);
        chk({tag, "_pass"},  {31'd0, pass_o},    32'd0);
        chk({tag, "_err"},   {31'd0, error_o},   32'd0);
        chk({tag, "_to"},    {31'd0, timeout_o}, 32'd0);
        chk({tag, "_idx"},   {30'd0, err_idx_o}, 32'd0);
        chk({tag, "_data"},  err_data_o,         32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Clean burst, back to back
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, words[i]);
            if (i < 3) chk("s1_busy_mid", {31'd0, busy_o}, 32'd1);
            if (i < 3) chk("s1_done_mid", {31'd0, done_o}, 32'd0);
        end
        chk("s1_done", {31'd0, done_o},  32'd1);
        chk("s1_pass", {31'd0, pass_o},  32'd1);
        chk("s1_err",  {31'd0, error_o}, 32'd0);
        chk("s1_busy", {31'd0, busy_o},  32'd0);
        step(0, 1, 32'hDEAD_BEEF);
        chk("s1_hold_pass", {31'd0, pass_o},  32'd1);
        chk("s1_hold_err",  {31'd0, error_o}, 32'd0);

        // Word 2 corrupted; start arrives with a stray word that must be dropped
        step(1, 1, 32'h1234_5678);
        step(0, 1, words[0]);
        step(0, 1, words[1]);
        step(0, 1, 32'h0000_0000);
        step(0, 1, words[3]);
        chk("s2_err",  {31'd0, error_o},   32'd1);
        chk("s2_idx",  {30'd0, err_idx_o}, 32'd2);
        chk("s2_data", err_data_o,         32'd0);
        chk("s2_pass", {31'd0, pass_o},    32'd0);
        chk("s2_done", {31'd0, done_o},    32'd1);

        // Gaps of 3 idle cycles between words
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, words[i]);
            if (i < 3) repeat (3) step(0, 0, 0);
        end
        chk("s3_pass", {31'd0, pass_o},    32'd1);
        chk("s3_to",   {31'd0, timeout_o}, 32'd0);

        // One word then a full idle window
        step(1, 0, 0);
        step(0, 1, words[0]);
        repeat (TO - 1) step(0, 0, 0);
        chk("s4_to_early",   {31'd0, timeout_o}, 32'd0);
        chk("s4_busy_early", {31'd0, busy_o},    32'd1);
        step(0, 0, 0);
        chk("s4_to",   {31'd0, timeout_o}, 32'd1);
        chk("s4_err",  {31'd0, error_o},   32'd1);
        chk("s4_idx",  {30'd0, err_idx_o}, 32'd1);
        chk("s4_pass", {31'd0, pass_o},    32'd0);

        // Asynchronous reset mid-burst
        step(1, 0, 0);
        step(0, 1, words[0]);
        step(0, 1, words[1]);
        #3 rst_n = 1'b0;
        #1 all_zero("s5_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, words[i]);
        chk("s5_pass", {31'd0, pass_o}, 32'd1);

        // Restart while armed
        step(1, 0, 0);
        step(0, 1, words[0]);
        step(0, 1, words[1]);
        step(1, 0, 0);
        chk("s6_busy", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, words[i]);
        chk("s6_pass", {31'd0, pass_o},  32'd1);
        chk("s6_err",  {31'd0, error_o}, 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 The module SHALL have parameter Depth, default 4, meaning the number of words per checked burst (Depth >= 2).
REQ-002 The module SHALL have parameter DataWidth, default 32, meaning the data word width (1..32).
REQ-003 The module SHALL have parameter Seed, default 32'hCAFE_0001, meaning the LFSR start value; it must be non-zero.
REQ-004 The module SHALL have parameter TimeoutCycles, default 64, meaning the maximum idle cycles allowed between accepted words while armed.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The module SHALL have port start_i, input, 1 bit: arm pulse; it loads Seed and clears status.
REQ-008 The module SHALL have ports valid_i (input, 1 bit) and data_i (input, DataWidth bits): the word stream from the shift-register output; there is no backpressure.
REQ-009 The module SHALL have port busy_o, output, 1 bit: high while armed.
REQ-010 The module SHALL have ports done_o, pass_o, error_o and timeout_o, each an output of 1 bit: sticky status flags.
REQ-011 The module SHALL have ports err_idx_o (output, $clog2(Depth) bits) and err_data_o (output, DataWidth bits): the index and the received value of the first mismatch.

Function
REQ-012 The FSM SHALL have states IDLE, ARMED, PASS and FAIL.
REQ-013 In IDLE, PASS or FAIL, start_i=1 SHALL load the LFSR with Seed, clear word count, idle counter and all status outputs, and move to ARMED on the next edge.
REQ-014 The expected word k SHALL be lfsr[DataWidth-1:0]: word 0 = Seed[DataWidth-1:0], and the LFSR advances once per accepted word.
REQ-015 The LFSR SHALL be a 32-bit Galois right-shift LFSR with taps 32'h8020_0003 (x^32+x^22+x^2+x+1).
REQ-016 In ARMED, a word SHALL be accepted on each edge where valid_i=1; gaps in valid_i are legal.
REQ-017 When an accepted word equals the expected word and the count is below Depth-1, the block SHALL increment the count, advance the LFSR and clear the idle counter.
REQ-018 When an accepted word equals the expected word and the count equals Depth-1, the block SHALL move to PASS and set done_o=1 and pass_o=1 on the next cycle.
REQ-019 When an accepted word differs from the expected word, the block SHALL move to FAIL, set done_o=1 and error_o=1, and latch err_idx_o = count and err_data_o = data_i; only the first mismatch is recorded.
REQ-020 In ARMED, the idle counter SHALL increment on each cycle with valid_i=0.
REQ-021 When the idle counter reaches TimeoutCycles, the block SHALL move to FAIL with done_o=1, error_o=1 and timeout_o=1, and err_idx_o = count.
REQ-022 valid_i SHALL be ignored in IDLE, PASS and FAIL; status outputs SHALL be held until the next start_i.
REQ-023 start_i asserted while in ARMED SHALL restart the check: reload Seed, clear the count and flags, and remain in ARMED.
REQ-024 If start_i and valid_i are high together in IDLE, PASS or FAIL, that word SHALL NOT be checked; checking begins on the following cycle.
REQ-025 busy_o SHALL equal (state == ARMED); all status outputs SHALL be registered.

Reset
REQ-026 rst_ni=0 SHALL asynchronously force state IDLE, LFSR = Seed, and zero the count and idle counter.
REQ-027 rst_ni=0 SHALL asynchronously force busy_o, done_o, pass_o, error_o, timeout_o, err_idx_o and err_data_o to 0.
REQ-028 A reset during ARMED SHALL abort the check without setting any flag.

Structure
REQ-029 Package stream_checker_pkg SHALL hold the state enum type, the LFSR tap constant and a function lfsr_next(logic [31:0]) returning logic [31:0].
REQ-030 The LFSR SHALL be a sub-module lfsr_gen with ports clk_i, rst_ni, load_i, seed_i, en_i and state_o.
REQ-031 The count and idle counters SHALL be sized $clog2(Depth) bits and $clog2(TimeoutCycles+1) bits respectively.

Verification
REQ-032 The bench SHALL cover this scenario: start_i pulse, then 4 consecutive words from lfsr_next starting at 32'hCAFE_0001 -> done_o=1 and pass_o=1 one cycle after word 3, and error_o=0.
REQ-033 The bench SHALL cover this scenario: the same stream with word 2 replaced by 32'h0000_0000 -> error_o=1, err_idx_o=2, err_data_o=0, pass_o=0.
REQ-034 The bench SHALL cover this scenario: correct words with 3 idle cycles between each -> pass_o=1; no timeout.
REQ-035 The bench SHALL cover this scenario: start_i, 1 correct word, then 64 idle cycles -> timeout_o=1, error_o=1, err_idx_o=1.
REQ-036 The bench SHALL cover this scenario: rst_ni driven low mid-burst after 2 words -> all outputs 0 immediately; then start_i plus a full correct burst -> pass_o=1.
REQ-037 The bench SHALL cover this scenario: start_i reasserted after 2 words, then a full burst from Seed -> pass_o=1.
